// File: rtl/replay_pkg.sv
// Shared sizing constants and FSM state encoding for the replay controller.
package replay_pkg;
  localparam int NUM_QUEUES         = 4;
  localparam int MEM_ADDR_WIDTH     = 19;
  localparam int REPLAY_COUNT_WIDTH = 32;
  localparam int WORD_CNT_WIDTH     = MEM_ADDR_WIDTH + 1 + REPLAY_COUNT_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FLUSH,
    ARM,
    RUN,
    STOP
  } state_t;
endpackage

// File: rtl/replay_word_counter.sv
// Per-queue expected-word target, running word count and sticky done flag.
module replay_word_counter #(
  parameter int ADDR_W  = 19,
  parameter int COUNT_W = 32,
  parameter int CNT_W   = ADDR_W + 1 + COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_target,
  input  logic [ADDR_W-1:0]  low,
  input  logic [ADDR_W-1:0]  high,
  input  logic [COUNT_W-1:0] replay_count,
  input  logic               clear_count,
  input  logic               clear_done,
  input  logic               count_en,
  output logic               done
);
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  assign count_next = count + CNT_W'(1);

  // Each SRAM word yields two FIFO words, repeated replay_count times.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target <= '0;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      if (load_target)
        target <= (CNT_W'(high - low) << 1) * CNT_W'(replay_count);
      if (clear_count)
        count <= '0;
      else if (count_en && !done)
        count <= count_next;
      if (clear_done)
        done <= 1'b0;
      else if (count_en && !done && count_next == target)
        done <= 1'b1;
    end
  end
endmodule

// File: rtl/replay_ctrl.sv
// Replay controller: validates per-queue regions, sequences the replay engine
// through soft reset, calibration wait and run, and tracks per-queue completion.
module replay_ctrl #(
  parameter int NUM_QUEUES         = replay_pkg::NUM_QUEUES,
  parameter int MEM_ADDR_WIDTH     = replay_pkg::MEM_ADDR_WIDTH,
  parameter int REPLAY_COUNT_WIDTH = replay_pkg::REPLAY_COUNT_WIDTH,
  localparam int WORD_CNT_WIDTH    = MEM_ADDR_WIDTH + 1 + REPLAY_COUNT_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cal_done,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     cfg_addr_low,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     cfg_addr_high,
  input  logic [NUM_QUEUES*REPLAY_COUNT_WIDTH-1:0] cfg_replay_count,
  input  logic [NUM_QUEUES-1:0]                    cfg_enable,
  input  logic                                     ctrl_start,
  input  logic                                     ctrl_stop,
  input  logic [NUM_QUEUES-1:0]                    fifo_wr_en,
  output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     q_addr_low,
  output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     q_addr_high,
  output logic [NUM_QUEUES*REPLAY_COUNT_WIDTH-1:0] q_replay_count,
  output logic [NUM_QUEUES-1:0]                    q_start_replay,
  output logic [NUM_QUEUES-1:0]                    q_enable,
  output logic                                     eng_sw_rst,
  output logic                                     busy,
  output logic [NUM_QUEUES-1:0]                    q_done,
  output logic                                     all_done,
  output logic                                     cfg_error
);
  import replay_pkg::*;

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int RW = REPLAY_COUNT_WIDTH;

  state_t                 state;
  logic                   phase;
  logic [NUM_QUEUES*AW-1:0] sh_low;
  logic [NUM_QUEUES*AW-1:0] sh_high;
  logic [NUM_QUEUES*RW-1:0] sh_count;
  logic [NUM_QUEUES-1:0]  sh_en;
  logic [NUM_QUEUES-1:0]  done_vec;
  logic                   cfg_bad;
  logic                   sw_rst_r;
  logic                   all_done_r;
  logic                   cfg_error_r;
  logic                   accept_start;

  assign accept_start = (state == IDLE) && ctrl_start && !ctrl_stop;

  // Regions are half-open, so touching regions [a,b) and [b,c) do not overlap.
  always_comb begin
    cfg_bad = (sh_en == '0);
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (sh_en[i] && ((sh_low[i*AW +: AW] >= sh_high[i*AW +: AW]) ||
                       (sh_count[i*RW +: RW] == '0)))
        cfg_bad = 1'b1;
      for (int j = i + 1; j < NUM_QUEUES; j++) begin
        if (sh_en[i] && sh_en[j] &&
            (sh_low[i*AW +: AW] < sh_high[j*AW +: AW]) &&
            (sh_low[j*AW +: AW] < sh_high[i*AW +: AW]))
          cfg_bad = 1'b1;
      end
    end
  end

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_cnt
    replay_word_counter #(
      .ADDR_W (AW),
      .COUNT_W(RW),
      .CNT_W  (WORD_CNT_WIDTH)
    ) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_target (state == CHECK),
      .low         (sh_low[q*AW +: AW]),
      .high        (sh_high[q*AW +: AW]),
      .replay_count(sh_count[q*RW +: RW]),
      .clear_count (state == FLUSH),
      .clear_done  (accept_start),
      .count_en    ((state == RUN) && sh_en[q] && fifo_wr_en[q]),
      .done        (done_vec[q])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= 1'b0;
      sh_low      <= '0;
      sh_high     <= '0;
      sh_count    <= '0;
      sh_en       <= '0;
      sw_rst_r    <= 1'b1;
      all_done_r  <= 1'b0;
      cfg_error_r <= 1'b0;
    end else begin
      all_done_r <= 1'b0;
      case (state)
        IDLE: begin
          sw_rst_r <= 1'b0;
          if (accept_start) begin
            sh_low      <= cfg_addr_low;
            sh_high     <= cfg_addr_high;
            sh_count    <= cfg_replay_count;
            sh_en       <= cfg_enable;
            cfg_error_r <= 1'b0;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (ctrl_stop) begin
            state    <= STOP;
            sw_rst_r <= 1'b1;
            phase    <= 1'b0;
          end else if (cfg_bad) begin
            cfg_error_r <= 1'b1;
            state       <= IDLE;
          end else begin
            state    <= FLUSH;
            sw_rst_r <= 1'b1;
            phase    <= 1'b0;
          end
        end
        FLUSH: begin
          if (ctrl_stop) begin
            state    <= STOP;
            sw_rst_r <= 1'b1;
            phase    <= 1'b0;
          end else if (phase) begin
            sw_rst_r <= 1'b0;
            state    <= ARM;
          end else begin
            phase <= 1'b1;
          end
        end
        ARM: begin
          if (ctrl_stop) begin
            state    <= STOP;
            sw_rst_r <= 1'b1;
            phase    <= 1'b0;
          end else if (cal_done) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (ctrl_stop) begin
            state    <= STOP;
            sw_rst_r <= 1'b1;
            phase    <= 1'b0;
          end else if ((done_vec & sh_en) == sh_en) begin
            all_done_r <= 1'b1;
            state      <= IDLE;
          end else if (!cal_done) begin
            state <= ARM;
          end
        end
        STOP: begin
          if (phase) begin
            sw_rst_r <= 1'b0;
            state    <= IDLE;
          end else begin
            phase <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign q_addr_low     = sh_low;
  assign q_addr_high    = sh_high;
  assign q_replay_count = sh_count;
  assign q_enable       = (state == STOP) ? '0 : sh_en;
  assign q_start_replay = (state == RUN) ? (sh_en & ~done_vec) : '0;
  assign eng_sw_rst     = sw_rst_r;
  assign busy           = (state != IDLE);
  assign q_done         = done_vec;
  assign all_done       = all_done_r;
  assign cfg_error      = cfg_error_r;
endmodule

// File: tb/tb_replay_ctrl.sv
// Directed bench for replay_ctrl: happy path, config errors, interleaved
// completion, stop, calibration loss and mid-run reset.
module tb_replay_ctrl;
  localparam int NQ = 4;
  localparam int AW = 19;
  localparam int RW = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cal_done = 1'b0;
  logic [NQ*AW-1:0]   cfg_addr_low;
  logic [NQ*AW-1:0]   cfg_addr_high;
  logic [NQ*RW-1:0]   cfg_replay_count;
  logic [NQ-1:0]      cfg_enable;
  logic               ctrl_start = 1'b0;
  logic               ctrl_stop = 1'b0;
  logic [NQ-1:0]      fifo_wr_en = '0;
  logic [NQ*AW-1:0]   q_addr_low;
  logic [NQ*AW-1:0]   q_addr_high;
  logic [NQ*RW-1:0]   q_replay_count;
  logic [NQ-1:0]      q_start_replay;
  logic [NQ-1:0]      q_enable;
  logic               eng_sw_rst;
  logic               busy;
  logic [NQ-1:0]      q_done;
  logic               all_done;
  logic               cfg_error;

  int compared = 0;
  int mismatched = 0;

  replay_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cal_done        (cal_done),
    .cfg_addr_low    (cfg_addr_low),
    .cfg_addr_high   (cfg_addr_high),
    .cfg_replay_count(cfg_replay_count),
    .cfg_enable      (cfg_enable),
    .ctrl_start      (ctrl_start),
    .ctrl_stop       (ctrl_stop),
    .fifo_wr_en      (fifo_wr_en),
    .q_addr_low      (q_addr_low),
    .q_addr_high     (q_addr_high),
    .q_replay_count  (q_replay_count),
    .q_start_replay  (q_start_replay),
    .q_enable        (q_enable),
    .eng_sw_rst      (eng_sw_rst),
    .busy            (busy),
    .q_done          (q_done),
    .all_done        (all_done),
    .cfg_error       (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic start, input logic stop, input logic [NQ-1:0] wr);
    ctrl_start = start;
    ctrl_stop  = stop;
    fifo_wr_en = wr;
  endtask

  task automatic clear_cfg();
    cfg_addr_low     = '0;
    cfg_addr_high    = '0;
    cfg_replay_count = '0;
    cfg_enable       = '0;
  endtask

  task automatic set_q(input int q, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                       input logic [RW-1:0] cnt, input logic en);
    cfg_addr_low[q*AW +: AW]     = lo;
    cfg_addr_high[q*AW +: AW]    = hi;
    cfg_replay_count[q*RW +: RW] = cnt;
    cfg_enable[q]                = en;
  endtask

  initial begin
    clear_cfg();
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    rst_n = 1'b0;
    step();
    step();
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_sw_rst", 64'(eng_sw_rst), 64'd1);
    check_output("rst_q_done", 64'(q_done), 64'd0);
    check_output("rst_all_done", 64'(all_done), 64'd0);
    check_output("rst_cfg_error", 64'(cfg_error), 64'd0);
    check_output("rst_start_replay", 64'(q_start_replay), 64'd0);
    check_output("rst_q_enable", 64'(q_enable), 64'd0);
    check_output("rst_addr_low", 64'(q_addr_low[AW-1:0]), 64'd0);
    rst_n = 1'b1;
    step();
    check_output("post_rst_sw_rst", 64'(eng_sw_rst), 64'd0);

    // start and stop together in IDLE: nothing happens
    set_q(0, 19'h100, 19'h104, 32'd3, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'b0000);
    step();
    check_output("stop_wins_busy", 64'(busy), 64'd0);
    check_output("stop_wins_no_latch", 64'(q_addr_low[AW-1:0]), 64'd0);

    // single queue, target (4*2*3)=24
    cal_done = 1'b1;
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    step();
    check_output("t1_busy", 64'(busy), 64'd1);
    check_output("t1_addr_low", 64'(q_addr_low[AW-1:0]), 64'h100);
    check_output("t1_addr_high", 64'(q_addr_high[AW-1:0]), 64'h104);
    check_output("t1_count", 64'(q_replay_count[RW-1:0]), 64'd3);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t1_flush1", 64'(eng_sw_rst), 64'd1);
    step();
    check_output("t1_flush2", 64'(eng_sw_rst), 64'd1);
    step();
    check_output("t1_arm_sw_rst", 64'(eng_sw_rst), 64'd0);
    check_output("t1_arm_start", 64'(q_start_replay), 64'd0);
    step();
    check_output("t1_run_start", 64'(q_start_replay), 64'b0001);
    check_output("t1_run_enable", 64'(q_enable), 64'b0001);
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    repeat (23) step();
    check_output("t1_done_23", 64'(q_done), 64'd0);
    step();
    check_output("t1_done_24", 64'(q_done), 64'b0001);
    check_output("t1_start_drop", 64'(q_start_replay), 64'd0);
    check_output("t1_no_early_all", 64'(all_done), 64'd0);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t1_all_done", 64'(all_done), 64'd1);
    check_output("t1_idle", 64'(busy), 64'd0);
    step();
    check_output("t1_all_done_pulse", 64'(all_done), 64'd0);

    // overlapping regions
    clear_cfg();
    set_q(0, 19'h0, 19'h10, 32'd1, 1'b1);
    set_q(1, 19'h8, 19'h20, 32'd1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    step();
    check_output("t2_q_done_cleared", 64'(q_done), 64'd0);
    check_output("t2_check_sw_rst", 64'(eng_sw_rst), 64'd0);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t2_cfg_error", 64'(cfg_error), 64'd1);
    check_output("t2_busy", 64'(busy), 64'd0);
    check_output("t2_sw_rst", 64'(eng_sw_rst), 64'd0);

    // zero replay count on an enabled queue
    clear_cfg();
    set_q(0, 19'h0, 19'h10, 32'd1, 1'b1);
    set_q(2, 19'h40, 19'h50, 32'd0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    step();
    check_output("t3_err_cleared", 64'(cfg_error), 64'd0);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t3_count0_err", 64'(cfg_error), 64'd1);
    check_output("t3_busy", 64'(busy), 64'd0);

    // nothing enabled
    clear_cfg();
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    step();
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t3_none_err", 64'(cfg_error), 64'd1);

    // q0 target 2*2*2=8, q1 target 1*2*2=4, final strobes together
    clear_cfg();
    set_q(0, 19'h0, 19'h2, 32'd2, 1'b1);
    set_q(1, 19'h10, 19'h11, 32'd2, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    step();
    check_output("t4_err_cleared", 64'(cfg_error), 64'd0);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    repeat (4) step();
    check_output("t4_run_start", 64'(q_start_replay), 64'b0011);
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    repeat (4) step();
    apply_stimulus(1'b0, 1'b0, 4'b0010);
    step();
    apply_stimulus(1'b0, 1'b0, 4'b0011);
    repeat (2) step();
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    step();
    check_output("t4_done_before", 64'(q_done), 64'd0);
    check_output("t4_start_before", 64'(q_start_replay), 64'b0011);
    apply_stimulus(1'b0, 1'b0, 4'b0011);
    step();
    check_output("t4_done_both", 64'(q_done), 64'b0011);
    check_output("t4_start_drop", 64'(q_start_replay), 64'd0);
    check_output("t4_no_early_all", 64'(all_done), 64'd0);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t4_all_done", 64'(all_done), 64'd1);
    check_output("t4_idle", 64'(busy), 64'd0);
    step();
    check_output("t4_single_pulse", 64'(all_done), 64'd0);

    // start held through ARM without calibration
    clear_cfg();
    set_q(0, 19'h0, 19'h2, 32'd2, 1'b1);
    cal_done = 1'b0;
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    repeat (6) step();
    check_output("t5_arm_busy", 64'(busy), 64'd1);
    check_output("t5_arm_sw_rst", 64'(eng_sw_rst), 64'd0);
    check_output("t5_arm_start", 64'(q_start_replay), 64'd0);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    cal_done = 1'b1;
    step();
    check_output("t5_run_start", 64'(q_start_replay), 64'b0001);

    // stop after 5 of 8 words
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    repeat (5) step();
    check_output("t6_partial_done", 64'(q_done), 64'd0);
    apply_stimulus(1'b0, 1'b1, 4'b0000);
    step();
    check_output("t6_stop_start", 64'(q_start_replay), 64'd0);
    check_output("t6_stop_enable", 64'(q_enable), 64'd0);
    check_output("t6_stop_sw_rst1", 64'(eng_sw_rst), 64'd1);
    check_output("t6_stop_busy", 64'(busy), 64'd1);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t6_stop_sw_rst2", 64'(eng_sw_rst), 64'd1);
    step();
    check_output("t6_sw_rst_off", 64'(eng_sw_rst), 64'd0);
    check_output("t6_idle", 64'(busy), 64'd0);
    check_output("t6_q_done", 64'(q_done), 64'd0);
    check_output("t6_no_all_done", 64'(all_done), 64'd0);

    // calibration loss mid-run holds the count
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    step();
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    repeat (4) step();
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    repeat (3) step();
    cal_done = 1'b0;
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t7_arm_start", 64'(q_start_replay), 64'd0);
    check_output("t7_arm_busy", 64'(busy), 64'd1);
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    repeat (2) step();
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    cal_done = 1'b1;
    step();
    check_output("t7_rerun_start", 64'(q_start_replay), 64'b0001);
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    repeat (4) step();
    check_output("t7_done_7", 64'(q_done), 64'd0);
    step();
    check_output("t7_done_8", 64'(q_done), 64'b0001);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t7_all_done", 64'(all_done), 64'd1);

    // reset mid-run
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    step();
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    repeat (4) step();
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    check_output("t8_busy", 64'(busy), 64'd0);
    check_output("t8_start", 64'(q_start_replay), 64'd0);
    check_output("t8_enable", 64'(q_enable), 64'd0);
    check_output("t8_q_done", 64'(q_done), 64'd0);
    check_output("t8_all_done", 64'(all_done), 64'd0);
    check_output("t8_sw_rst", 64'(eng_sw_rst), 64'd1);
    check_output("t8_addr_low", 64'(q_addr_low[AW-1:0]), 64'd0);
    check_output("t8_count", 64'(q_replay_count[RW-1:0]), 64'd0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    step();
    check_output("t8_sw_rst_off", 64'(eng_sw_rst), 64'd0);
    check_output("t8_no_all_done", 64'(all_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
